// File: rtl/audio_capture_pkg.sv
// Shared types and helpers for the audio frame capture block: FSM encoding,
// sample width, mono mixing and saturating absolute value.
package audio_capture_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  // |x| with the single unrepresentable case (-32768) clamped to +32767.
  function automatic logic [SAMPLE_W-1:0] sat_abs16(input logic [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] r;
    if (x == 16'h8000)  r = 16'h7FFF;
    else if (x[SAMPLE_W-1]) r = -x;
    else                r = x;
    return r;
  endfunction

  // Average of two signed samples computed in 17 bits, so it never overflows.
  function automatic logic [SAMPLE_W-1:0] mono_mix(input logic [SAMPLE_W-1:0] l16,
                                                   input logic [SAMPLE_W-1:0] r16);
    logic [SAMPLE_W:0] s;
    s = {l16[SAMPLE_W-1], l16} + {r16[SAMPLE_W-1], r16};
    return s[SAMPLE_W:1];
  endfunction

endpackage

// File: rtl/audio_frame_ram.sv
// Simple dual-port frame buffer: one synchronous write port and one registered
// read port sharing the same clock.
module audio_frame_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_frame_capture.sv
// Drains the audio input FIFO, mixes to mono, boxcar-decimates, and captures a
// voice-triggered frame into RAM for the recognition datapath.
module audio_frame_capture
  import audio_capture_pkg::*;
#(
  parameter int          DECIM     = 4,
  parameter int          FRAME_LEN = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] THRESH    = 16'h0800
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              audio_in_available,
  input  logic [31:0]       left_channel_audio_in,
  input  logic [31:0]       right_channel_audio_in,
  output logic              read_audio_in,
  input  logic              arm,
  output logic              frame_ready,
  input  logic              frame_done_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic [15:0]       level,
  output logic [1:0]        state
);

  localparam int LOG2_DECIM = $clog2(DECIM);
  localparam int ACC_W      = SAMPLE_W + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] CNT_LAST  = LOG2_DECIM'(DECIM - 1);
  localparam logic [ADDR_W-1:0]     WPTR_LAST = ADDR_W'(FRAME_LEN - 1);

  // The FIFO is always drained, independent of capture state.
  assign read_audio_in = audio_in_available;

  logic                    accept;
  logic [SAMPLE_W-1:0]     mono;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_sum;
  logic [LOG2_DECIM-1:0]   cnt_q;
  logic                    dec_valid;
  logic [SAMPLE_W-1:0]     dec_sample;
  logic [SAMPLE_W-1:0]     dec_abs;

  logic unused_low_bits;
  assign unused_low_bits = ^{left_channel_audio_in[15:0], right_channel_audio_in[15:0]};

  assign accept     = audio_in_available;
  assign mono       = mono_mix(left_channel_audio_in[31:16], right_channel_audio_in[31:16]);
  assign acc_sum    = acc_q + {{LOG2_DECIM{mono[SAMPLE_W-1]}}, mono};
  assign dec_valid  = accept && (cnt_q == CNT_LAST);
  // Taking the top SAMPLE_W bits of the sum is the arithmetic shift by log2(DECIM).
  assign dec_sample = acc_sum[ACC_W-1 -: SAMPLE_W];
  assign dec_abs    = sat_abs16(dec_sample);

  // NOTE: sequential state uses non-blocking assignments only; combinational logic uses blocking.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      level <= '0;
    end else begin
      if (accept) begin
        if (dec_valid) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (dec_valid) level <= dec_abs;
    end
  end

  cap_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;

  // NOTE: every output of this block is defaulted first so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    ram_we    = 1'b0;
    ram_waddr = wptr_q;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          wptr_d  = '0;
        end
      end
      ARMED: begin
        if (dec_valid && (dec_abs >= THRESH)) begin
          ram_we    = 1'b1;
          ram_waddr = '0;
          wptr_d    = ADDR_W'(1);
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (dec_valid) begin
          ram_we = 1'b1;
          if (wptr_q == WPTR_LAST) state_d = DONE;
          else                     wptr_d  = wptr_q + 1'b1;
        end
      end
      DONE: begin
        if (frame_done_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      frame_ready <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      frame_ready <= (state_d == DONE);
    end
  end

  assign state = state_q;

  audio_frame_ram #(
    .DEPTH  (FRAME_LEN),
    .ADDR_W (ADDR_W),
    .DATA_W (SAMPLE_W)
  ) u_ram (
    .clk   (CLOCK_50),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (dec_sample),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_audio_frame_capture.sv
// Directed bench for audio_frame_capture with DECIM=4, FRAME_LEN=8.
module tb_audio_frame_capture;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        audio_in_available;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic        arm;
  logic        frame_ready;
  logic        frame_done_ack;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] level;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  audio_frame_capture #(
    .DECIM     (4),
    .FRAME_LEN (8),
    .ADDR_W    (3),
    .THRESH    (16'h0800)
  ) dut (
    .CLOCK_50               (CLOCK_50),
    .reset                  (reset),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (left_channel_audio_in),
    .right_channel_audio_in (right_channel_audio_in),
    .read_audio_in          (read_audio_in),
    .arm                    (arm),
    .frame_ready            (frame_ready),
    .frame_done_ack         (frame_done_ack),
    .rd_addr                (rd_addr),
    .rd_data                (rd_data),
    .level                  (level),
    .state                  (state)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int gap);
    audio_in_available     = 1'b1;
    left_channel_audio_in  = l;
    right_channel_audio_in = r;
    @(negedge CLOCK_50);
    audio_in_available = 1'b0;
    repeat (gap) @(negedge CLOCK_50);
  endtask

  // Four identical pairs whose mono mix is m.
  task automatic send_window(input logic [15:0] m);
    for (int i = 0; i < 4; i++) send_pair({m, 16'h0}, {m, 16'h0}, int'($urandom_range(0, 2)));
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge CLOCK_50);
    arm = 1'b0;
  endtask

  logic [15:0] exp_frame [8];

  initial begin
    reset                  = 1'b1;
    audio_in_available     = 1'b0;
    left_channel_audio_in  = '0;
    right_channel_audio_in = '0;
    arm                    = 1'b0;
    frame_done_ack         = 1'b0;
    rd_addr                = '0;

    // 1. reset with toggling availability
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      audio_in_available = i[0];
      #1 check("read_mirror_rst", {31'b0, read_audio_in}, {31'b0, audio_in_available});
    end
    check("rst_state", {30'b0, state}, 32'd0);
    check("rst_frame_ready", {31'b0, frame_ready}, 32'd0);
    check("rst_level", {16'b0, level}, 32'd0);
    check("rst_rd_data", {16'b0, rd_data}, 32'd0);
    @(negedge CLOCK_50);
    audio_in_available = 1'b0;
    reset = 1'b0;
    @(negedge CLOCK_50);

    // 2. decimation of a mixed stereo window with gaps
    for (int i = 0; i < 3; i++) send_pair(32'h1000_0000, 32'h3000_0000, int'($urandom_range(0, 3)));
    check("no_dec_after_3", {16'b0, level}, 32'd0);
    send_pair(32'h1000_0000, 32'h3000_0000, 1);
    check("level_2000", {16'b0, level}, 32'h2000);
    check("idle_after_dec", {30'b0, state}, 32'd0);

    // 3. trigger and capture
    pulse_arm();
    check("armed", {30'b0, state}, 32'd1);
    for (int i = 0; i < 3; i++) send_window(16'h0100);
    check("quiet_stays_armed", {30'b0, state}, 32'd1);
    check("level_0100", {16'b0, level}, 32'h0100);
    send_window(16'h0800);
    check("trigger_capture", {30'b0, state}, 32'd2);
    rd_addr = 3'd0;
    @(negedge CLOCK_50);
    check("ram0_0800", {16'b0, rd_data}, 32'h0800);
    exp_frame[0] = 16'h0800;
    for (int k = 1; k < 8; k++) begin
      send_window(16'(k));
      exp_frame[k] = 16'(k);
    end
    check("frame_ready", {31'b0, frame_ready}, 32'd1);
    check("state_done", {30'b0, state}, 32'd3);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      @(negedge CLOCK_50);
      check($sformatf("rd_%0d", a), {16'b0, rd_data}, {16'b0, exp_frame[a]});
    end
    send_window(16'h0900);
    check("done_blocks_writes", {16'b0, rd_data}, 32'h0007);
    frame_done_ack = 1'b1;
    @(negedge CLOCK_50);
    frame_done_ack = 1'b0;
    check("ack_idle", {30'b0, state}, 32'd0);
    check("ack_clears_ready", {31'b0, frame_ready}, 32'd0);

    // 4. negative full scale triggers with saturated level
    pulse_arm();
    send_window(16'h8000);
    check("level_sat", {16'b0, level}, 32'h7FFF);
    check("negfs_capture", {30'b0, state}, 32'd2);
    rd_addr = 3'd0;
    @(negedge CLOCK_50);
    check("ram0_8000", {16'b0, rd_data}, 32'h8000);

    // 5. arm during capture is ignored; ack beats arm in DONE
    send_window(16'h0021);
    pulse_arm();
    check("arm_in_capture", {30'b0, state}, 32'd2);
    for (int k = 2; k < 7; k++) send_window(16'h0020 + 16'(k));
    check("still_capture", {30'b0, state}, 32'd2);
    send_window(16'h0027);
    check("done_after_7", {30'b0, state}, 32'd3);
    rd_addr = 3'd7;
    @(negedge CLOCK_50);
    check("ram7_0027", {16'b0, rd_data}, 32'h0027);
    arm = 1'b1;
    frame_done_ack = 1'b1;
    @(negedge CLOCK_50);
    arm = 1'b0;
    frame_done_ack = 1'b0;
    check("ack_wins_state", {30'b0, state}, 32'd0);
    check("ack_wins_ready", {31'b0, frame_ready}, 32'd0);
    send_window(16'h0800);
    check("no_capture_without_arm", {30'b0, state}, 32'd0);

    // 6. reset mid-capture, then a clean frame
    pulse_arm();
    send_window(16'h0800);
    send_window(16'h0002);
    send_window(16'h0003);
    check("three_writes", {30'b0, state}, 32'd2);
    rd_addr = 3'd0;
    send_pair(32'h4000_0000, 32'h4000_0000, 0);
    send_pair(32'h4000_0000, 32'h4000_0000, 0);
    reset = 1'b1;
    #1;
    check("midrst_state", {30'b0, state}, 32'd0);
    check("midrst_ready", {31'b0, frame_ready}, 32'd0);
    check("midrst_level", {16'b0, level}, 32'd0);
    check("midrst_rd_data", {16'b0, rd_data}, 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    pulse_arm();
    send_window(16'h0900);
    exp_frame[0] = 16'h0900;
    for (int k = 1; k < 8; k++) begin
      send_window(16'h0010 + 16'(k));
      exp_frame[k] = 16'h0010 + 16'(k);
    end
    check("clean_done", {30'b0, state}, 32'd3);
    check("clean_ready", {31'b0, frame_ready}, 32'd1);
    check("clean_level", {16'b0, level}, 32'h0017);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      @(negedge CLOCK_50);
      check($sformatf("clean_rd_%0d", a), {16'b0, rd_data}, {16'b0, exp_frame[a]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_frame_capture.md
Name: audio_frame_capture

Overview:
Downstream consumer of the Audio_Controller input FIFO. It drains left/right samples and mixes them to mono. It decimates the mono stream by boxcar averaging, then waits for a voice-activity trigger and captures a fixed-length frame into on-chip RAM for the digit-recognition datapath. It also exports a level value that drives LEDR.

Parameters:
DECIM, 4, decimation factor; power of 2, at least 2
FRAME_LEN, 256, decimated samples per frame; power of 2
ADDR_W, 8, log2(FRAME_LEN)
THRESH, 16'h0800, trigger level; a frame starts when |decimated sample| >= THRESH

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
audio_in_available  in  1  Audio_Controller has a sample pair ready
left_channel_audio_in  in  32  left sample, MSB-aligned signed
right_channel_audio_in  in  32  right sample, MSB-aligned signed
read_audio_in  out  1  pops one sample pair from Audio_Controller
arm  in  1  single-cycle request to start waiting for a trigger
frame_ready  out  1  high while a complete frame is held in RAM
frame_done_ack  in  1  downstream has finished reading the frame
rd_addr  in  ADDR_W  frame RAM read address
rd_data  out  16  frame RAM data, one-cycle registered latency
level  out  16  |last decimated sample|, saturated
state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE

Behaviour:
- Reset is asynchronous and active-high, as already decided. All registers clear on reset: state=IDLE, frame_ready=0, level=0, rd_data=0, decimation counter=0, accumulator=0, write pointer=0. RAM contents are not cleared.
- read_audio_in = audio_in_available, combinational, in every state. Input is always drained so the controller never overflows. A sample is accepted in any cycle with audio_in_available=1. Gaps between samples have no effect.
- Mono mix: sign-extend L[31:16] and R[31:16] to 17 bits, add, arithmetic shift right by 1, keep 16 bits. This cannot overflow.
- Decimation:
  - 16+log2(DECIM)-bit signed accumulator and a counter 0..DECIM-1. Both advance only on accepted samples and run in all states, so phase is continuous.
  - On the accepted sample with counter=DECIM-1: dec_sample = (acc + mono) >>> log2(DECIM). dec_valid pulses for one cycle. Accumulator reloads to 0 and counter wraps to 0.
- abs: |x|, with 16'h8000 saturating to 16'h7FFF. level updates on every dec_valid.
- FSM:
  - IDLE: arm=1 moves to ARMED and clears the write pointer. A dec_valid in the same cycle as arm is not evaluated.
  - ARMED: on dec_valid with abs >= THRESH, write the sample to addr 0, set wptr=1, move to CAPTURE. Quieter samples are discarded.
  - CAPTURE: each dec_valid writes to addr wptr and increments wptr. The write with wptr=FRAME_LEN-1 moves to DONE and sets frame_ready=1 on the next cycle edge. The pointer does not wrap into addr 0.
  - DONE: writes are blocked. frame_done_ack=1 moves to IDLE and clears frame_ready.
  - arm is ignored in ARMED, CAPTURE and DONE. If arm and frame_done_ack are both high in DONE, ack wins (go to IDLE) and arm is dropped.
  - frame_done_ack is ignored outside DONE.
- Read port: rd_data <= RAM[rd_addr] on every clock in every state, one-cycle latency. Data is meaningful only while frame_ready=1.
- Reset mid-CAPTURE abandons the partial frame and returns to IDLE. A new arm and a new trigger are required.

Decomposition:
- Package audio_capture_pkg holds:
  - SAMPLE_W=16 and the state encodings IDLE/ARMED/CAPTURE/DONE;
  - function sat_abs16;
  - function mono_mix(l16, r16).
- One sub-module, audio_frame_ram: simple dual-port inferred RAM, FRAME_LEN x 16. It has a write port (we, waddr, wdata) and a registered read port (raddr, rdata) on the same clock.

Test Plan:
All scenarios use DECIM=4, FRAME_LEN=8, ADDR_W=3, THRESH=16'h0800.
1. Reset, with audio_in_available toggling -> state=0, frame_ready=0, level=0, rd_data=0; read_audio_in mirrors audio_in_available every cycle.
2. Four pairs L=32'h1000_0000, R=32'h3000_0000 spaced by random idle gaps -> one dec_valid; level=16'h2000. No dec_valid after only 3 pairs.
3. Trigger and capture:
   - Arm, then feed 3 windows of mono 16'h0100 -> stays ARMED.
   - One window of 16'h0800 -> CAPTURE, RAM[0]=16'h0800.
   - 7 windows of values 1..7 -> frame_ready=1 and state=3.
   - rd_addr 0..7 returns 0800,0001..0007, each one cycle later.
4. Negative full scale, L=R=32'h8000_0000 after arm -> dec_sample 16'h8000, level=16'h7FFF, capture triggers.
5. Handshake conflicts:
   - arm pulse during CAPTURE -> no effect, wptr continues.
   - In DONE, arm and frame_done_ack in the same cycle -> IDLE, frame_ready=0.
   - A later trigger-level window does not start a capture without a new arm.
6. Assert reset after 3 CAPTURE writes -> immediate IDLE, frame_ready=0, counter and accumulator cleared. Re-arm plus trigger yields a full clean 8-sample frame.
